// File: rtl/cond_mod_counter.sv
// Condition-gated modulo counter: steps once per qualified AND of the condition inputs,
// counting up or down with wrap or saturate at the boundaries, plus clear, load and status pulses.
module cond_mod_counter #(
  parameter int unsigned IN_W     = 2,
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned MODULUS  = 4,
  parameter bit          SATURATE = 1'b0,
  parameter bit          EDGE     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  // Refuse to build with a modulus the register cannot represent.
  if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_param_check
    $error("cond_mod_counter: MODULUS must lie in 2..2**WIDTH");
  end

  // One decoded action per cycle, in priority order clear > load > step > hold.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_INC,
    ACT_WRAP_UP,
    ACT_DEC,
    ACT_WRAP_DN,
    ACT_SAT
  } action_e;

  action_e          action;
  logic             cond;
  logic             cond_q;
  logic             step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             sat_d;

  assign cond = &in;
  assign step = EDGE ? (cond & ~cond_q) : cond;

  // A full-range modulus makes every load legal, so the clamp compare is dropped.
  if (MODULUS == (64'(1) << WIDTH)) begin : g_load_full
    assign load_clamped = load_val;
  end else begin : g_load_clamp
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

  always_comb begin
    action = ACT_HOLD;
    if (clear) begin
      action = ACT_CLEAR;
    end else if (load) begin
      action = ACT_LOAD;
    end else if (step) begin
      if (!dir) begin
        if (count == MAX_VAL) action = SATURATE ? ACT_SAT : ACT_WRAP_UP;
        else                  action = ACT_INC;
      end else begin
        if (count == MIN_VAL) action = SATURATE ? ACT_SAT : ACT_WRAP_DN;
        else                  action = ACT_DEC;
      end
    end
  end

  // Boundary wraps are explicit so a power-of-two modulus never relies on overflow.
  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    unique case (action)
      ACT_HOLD:    count_d = count;
      ACT_CLEAR:   count_d = MIN_VAL;
      ACT_LOAD:    count_d = load_clamped;
      ACT_INC:     count_d = count + WIDTH'(1);
      ACT_WRAP_UP: begin
        count_d = MIN_VAL;
        wrap_d  = 1'b1;
      end
      ACT_DEC:     count_d = count - WIDTH'(1);
      ACT_WRAP_DN: begin
        count_d = MAX_VAL;
        wrap_d  = 1'b1;
      end
      ACT_SAT:     sat_d = 1'b1;
      default:     count_d = count;
    endcase
  end

  // cond_q tracks cond on clear/load cycles too, so a coincident edge is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= MIN_VAL;
      wrap   <= 1'b0;
      sat    <= 1'b0;
      cond_q <= 1'b0;
    end else begin
      count  <= count_d;
      wrap   <= wrap_d;
      sat    <= sat_d;
      cond_q <= cond;
    end
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == MIN_VAL);

endmodule

// File: tb/tb_cond_mod_counter.sv
// Bench for cond_mod_counter: four parameterisations share stimulus and are checked each
// cycle against an arithmetic reference model, plus directed literal expectations.
module tb_cond_mod_counter;

  localparam int P_INW [4] = '{2, 2, 2, 3};
  localparam int P_W   [4] = '{2, 4, 4, 3};
  localparam int P_M   [4] = '{4, 10, 10, 8};
  localparam int P_S   [4] = '{0, 0, 1, 0};
  localparam int P_E   [4] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] in_s = '0;
  logic       dir = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv_s = '0;

  logic [1:0] cnt0;
  logic [3:0] cnt1, cnt2;
  logic [2:0] cnt3;
  logic [3:0] amax, amin, wrp, st;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cond_mod_counter #(.IN_W(2), .WIDTH(2), .MODULUS(4), .SATURATE(1'b0), .EDGE(1'b0)) u0 (
    .clk(clk), .reset(reset), .in(in_s[1:0]), .dir(dir), .clear(clear), .load(load),
    .load_val(lv_s[1:0]), .count(cnt0), .at_max(amax[0]), .at_min(amin[0]), .wrap(wrp[0]), .sat(st[0]));
  cond_mod_counter #(.IN_W(2), .WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .EDGE(1'b0)) u1 (
    .clk(clk), .reset(reset), .in(in_s[1:0]), .dir(dir), .clear(clear), .load(load),
    .load_val(lv_s), .count(cnt1), .at_max(amax[1]), .at_min(amin[1]), .wrap(wrp[1]), .sat(st[1]));
  cond_mod_counter #(.IN_W(2), .WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .EDGE(1'b0)) u2 (
    .clk(clk), .reset(reset), .in(in_s[1:0]), .dir(dir), .clear(clear), .load(load),
    .load_val(lv_s), .count(cnt2), .at_max(amax[2]), .at_min(amin[2]), .wrap(wrp[2]), .sat(st[2]));
  cond_mod_counter #(.IN_W(3), .WIDTH(3), .MODULUS(8), .SATURATE(1'b0), .EDGE(1'b1)) u3 (
    .clk(clk), .reset(reset), .in(in_s), .dir(dir), .clear(clear), .load(load),
    .load_val(lv_s[2:0]), .count(cnt3), .at_max(amax[3]), .at_min(amin[3]), .wrap(wrp[3]), .sat(st[3]));

  task automatic check(input string name, input int idx, input integer act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic integer dut_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      default: return cnt3;
    endcase
  endfunction

  // Reference model: the counter rules in plain integer arithmetic.
  int m_cnt [4] = '{0, 0, 0, 0};
  int m_wrap[4] = '{0, 0, 0, 0};
  int m_sat [4] = '{0, 0, 0, 0};
  int m_cq  [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    int mask, cnd, stp, lv, top;
    for (int i = 0; i < 4; i++) begin
      mask = (1 << P_INW[i]) - 1;
      cnd  = ((int'(in_s) & mask) == mask) ? 1 : 0;
      top  = P_M[i] - 1;
      if (reset) begin
        m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0; m_cq[i] = 0;
      end else begin
        stp = (P_E[i] != 0) ? (cnd & (1 - m_cq[i])) : cnd;
        m_wrap[i] = 0;
        m_sat[i]  = 0;
        if (clear) begin
          m_cnt[i] = 0;
        end else if (load) begin
          lv = int'(lv_s) % (1 << P_W[i]);
          m_cnt[i] = (lv > top) ? top : lv;
        end else if (stp != 0) begin
          if (!dir) begin
            if (m_cnt[i] < top) m_cnt[i] = m_cnt[i] + 1;
            else if (P_S[i] != 0) m_sat[i] = 1;
            else begin m_cnt[i] = 0; m_wrap[i] = 1; end
          end else begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            else if (P_S[i] != 0) m_sat[i] = 1;
            else begin m_cnt[i] = top; m_wrap[i] = 1; end
          end
        end
        m_cq[i] = cnd;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        check("count", i, dut_cnt(i), m_cnt[i]);
        check("at_max", i, amax[i], (m_cnt[i] == P_M[i] - 1) ? 1 : 0);
        check("at_min", i, amin[i], (m_cnt[i] == 0) ? 1 : 0);
        check("wrap", i, wrp[i], m_wrap[i]);
        check("sat", i, st[i], m_sat[i]);
        check("wrap_sat_excl", i, wrp[i] & st[i], 0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  int exp_t1[5] = '{1, 2, 3, 0, 1};

  initial begin
    cyc(2);
    chk_en = 1'b1;
    check("lit_reset_cnt", 0, cnt0, 0);
    check("lit_reset_wrap", 0, wrp[0], 0);
    check("lit_reset_atmin", 0, amin[0], 1);

    // Default build stepping on level with both conditions high.
    reset = 1'b0;
    in_s  = 3'b111;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("lit_t1_cnt", k, cnt0, exp_t1[k]);
      check("lit_t1_wrap", k, wrp[0], (k == 3) ? 1 : 0);
    end
    in_s = 3'b001;
    cyc(2);
    check("lit_t1_hold", 0, cnt0, 1);

    // Mod-10 counting down from reset.
    reset = 1'b1; cyc(1);
    reset = 1'b0; dir = 1'b1; in_s = 3'b111;
    cyc(1);
    check("lit_t2_cnt", 0, cnt1, 9);
    check("lit_t2_wrap", 0, wrp[1], 1);
    check("lit_t2_amax", 0, amax[1], 1);
    cyc(1);
    check("lit_t2_cnt", 1, cnt1, 8);
    check("lit_t2_amax", 1, amax[1], 0);
    cyc(1);
    check("lit_t2_cnt", 2, cnt1, 7);

    // Saturating mod-10: clamped load, blocked step, then step down.
    reset = 1'b1; in_s = 3'b000; dir = 1'b0; cyc(1);
    reset = 1'b0; load = 1'b1; lv_s = 4'd12;
    cyc(1);
    check("lit_t3_load", 0, cnt2, 9);
    load = 1'b0; in_s = 3'b111;
    cyc(1);
    check("lit_t3_satcnt", 0, cnt2, 9);
    check("lit_t3_sat", 0, st[2], 1);
    dir = 1'b1;
    cyc(1);
    check("lit_t3_dn", 0, cnt2, 8);
    check("lit_t3_sat", 1, st[2], 0);

    // Edge-qualified stepping.
    reset = 1'b1; in_s = 3'b000; dir = 1'b0; cyc(1);
    reset = 1'b0; in_s = 3'b111;
    cyc(4);
    check("lit_t4_edge", 0, cnt3, 1);
    in_s = 3'b000; cyc(1);
    in_s = 3'b111; cyc(2);
    check("lit_t4_edge", 1, cnt3, 2);

    // A clear on a rising edge consumes that edge.
    in_s = 3'b000; cyc(1);
    clear = 1'b1; in_s = 3'b111;
    cyc(1);
    check("lit_t5_clr", 0, cnt3, 0);
    clear = 1'b0;
    cyc(2);
    check("lit_t5_consumed", 0, cnt3, 0);
    check("lit_t5_lvl", 0, cnt0, 2);

    // Priority clear over load over step.
    clear = 1'b1; load = 1'b1; lv_s = 4'd3; in_s = 3'b111;
    cyc(1);
    check("lit_t6_prio", 0, cnt0, 0);
    clear = 1'b0; in_s = 3'b000;
    cyc(1);
    check("lit_t6_load", 0, cnt0, 3);
    load = 1'b0;

    // Reset mid-count with the condition held high.
    reset = 1'b1; cyc(1);
    reset = 1'b0; in_s = 3'b111;
    cyc(2);
    check("lit_t7_pre", 0, cnt0, 2);
    reset = 1'b1;
    cyc(1);
    check("lit_t7_rst", 0, cnt0, 0);
    check("lit_t7_wrap", 0, wrp[0], 0);
    check("lit_t7_sat", 0, st[0], 0);
    reset = 1'b0;
    cyc(1);
    check("lit_t7_resume", 0, cnt0, 1);
    check("lit_t7_edge", 0, cnt3, 1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 99) < 3);
      load  = ($urandom_range(0, 99) < 4);
      lv_s  = 4'($urandom);
      in_s  = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'($urandom);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
